// File: rtl/i2c_reg_bridge_pkg.sv
// Shared constants for the I2C register bridge: register map and FSM state encoding.
package i2c_reg_pkg;

    localparam logic [6:0] REG_API    = 7'd0;
    localparam logic [6:0] REG_HDLVER = 7'd1;
    localparam logic [6:0] REG_CMD    = 7'd2;
    localparam logic [6:0] REG_STATUS = 7'd3;
    localparam logic [6:0] REG_DLEN   = 7'd4;
    localparam logic [6:0] REG_CLIP   = 7'd5;
    localparam logic [6:0] REG_LAST   = 7'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_COMMIT = 3'd3,
        ST_REARM  = 3'd4
    } state_t;

endpackage

// File: rtl/i2c_reg_bridge_if.sv
// Command handshake between the register bridge (master) and the fabric consumer (slave).
interface i2c_reg_bridge_if;

    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [7:0] Cmd_Word;
    logic       Cmd_Overrun;

    modport master (
        output Cmd_Valid,
        output Cmd_Word,
        output Cmd_Overrun,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid,
        input  Cmd_Word,
        input  Cmd_Overrun,
        output Cmd_Ready
    );

endinterface

// File: rtl/i2c_reg_bridge_sync_bit.sv
// Single-bit multi-flop synchronizer into the MClk domain, cleared by async active-low reset.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_reg_bridge.sv
// Carries I2C write bytes from the SCL domain into MClk, holds the control register file,
// and drives the fabric command handshake plus the registered read-back byte.
module i2c_reg_bridge
    import i2c_reg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         SETTLE_CYC  = 8,
    parameter logic [7:0] HDL_VER     = 8'h01,
    parameter logic [7:0] API_RST     = 8'h01
) (
    input  logic             MClk,
    input  logic             Rst_n,
    input  logic             Data_Ready_Flag,
    input  logic [7:0]       IOout,
    input  logic [6:0]       I2C_ADR,
    input  logic [7:0]       HDL_Status,
    i2c_reg_bridge_if.master cmd,
    output logic [7:0]       Data_Length,
    output logic [7:0]       Clip_No,
    output logic [7:0]       API_Ver,
    output logic [7:0]       Rd_Data,
    output logic [7:0]       Err_Cnt
);

    localparam logic [7:0] SETTLE_LOAD     = 8'(SETTLE_CYC - 1);
    localparam int         ADR_SYNC_STAGES = 2;

    logic       flag_s;
    logic       flag_d;
    logic       flag_rise;
    logic [6:0] adr_s;
    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic [7:0] wdat;
    logic [6:0] wadr;
    logic       cnt_load;
    logic       cnt_dec;
    logic       sample_en;
    logic       commit_en;
    logic       runt_err;
    logic       wr_api;
    logic       wr_cmd;
    logic       wr_dlen;
    logic       wr_clip;
    logic       wr_bad;
    logic       cmd_hs;
    logic [7:0] rd_nxt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_flag_sync (
        .clk   (MClk),
        .rst_n (Rst_n),
        .d     (Data_Ready_Flag),
        .q     (flag_s)
    );

    // The address copy here feeds only the read mux; the write path samples I2C_ADR once settled.
    for (genvar i = 0; i < 7; i++) begin : g_adr_sync
        sync_bit #(.SYNC_STAGES(ADR_SYNC_STAGES)) u_adr_sync (
            .clk   (MClk),
            .rst_n (Rst_n),
            .d     (I2C_ADR[i]),
            .q     (adr_s[i])
        );
    end

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            flag_d <= 1'b0;
        end else begin
            flag_d <= flag_s;
        end
    end

    assign flag_rise = flag_s & ~flag_d;

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (flag_rise) state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (!flag_s)               state_nxt = ST_IDLE;
                else if (settle_cnt == '0) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_REARM;
            ST_REARM:  if (!flag_s) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_load  = (state == ST_IDLE) && flag_rise;
        cnt_dec   = (state == ST_SETTLE) && flag_s && (settle_cnt != '0);
        sample_en = (state == ST_SAMPLE);
        commit_en = (state == ST_COMMIT);
        runt_err  = (state == ST_SETTLE) && !flag_s;
    end

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            settle_cnt <= '0;
            wdat       <= '0;
            wadr       <= '0;
        end else begin
            if (cnt_load) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (cnt_dec) begin
                settle_cnt <= settle_cnt - 8'd1;
            end
            if (sample_en) begin
                wdat <= IOout;
                wadr <= I2C_ADR;
            end
        end
    end

    assign wr_api  = commit_en && (wadr == REG_API);
    assign wr_cmd  = commit_en && (wadr == REG_CMD);
    assign wr_dlen = commit_en && (wadr == REG_DLEN);
    assign wr_clip = commit_en && (wadr == REG_CLIP);
    assign wr_bad  = commit_en && ((wadr == REG_HDLVER) || (wadr == REG_STATUS) || (wadr > REG_LAST));
    assign cmd_hs  = cmd.Cmd_Valid && cmd.Cmd_Ready;

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            API_Ver     <= API_RST;
            Data_Length <= '0;
            Clip_No     <= '0;
            Err_Cnt     <= '0;
        end else begin
            if (wr_api)              API_Ver     <= wdat;
            if (wr_dlen)             Data_Length <= wdat;
            if (wr_clip)             Clip_No     <= wdat;
            if (runt_err || wr_bad)  Err_Cnt     <= sat_inc(Err_Cnt);
        end
    end

    // A commit landing on the handshake cycle re-arms Cmd_Valid rather than losing the new word.
    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmd.Cmd_Word    <= '0;
            cmd.Cmd_Valid   <= 1'b0;
            cmd.Cmd_Overrun <= 1'b0;
        end else begin
            if (wr_cmd) begin
                cmd.Cmd_Word  <= wdat;
                cmd.Cmd_Valid <= 1'b1;
            end else if (cmd_hs) begin
                cmd.Cmd_Valid <= 1'b0;
            end
            if (wr_cmd && cmd.Cmd_Valid && !cmd.Cmd_Ready) begin
                cmd.Cmd_Overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_nxt = 8'h00;
        case (adr_s)
            REG_API:    rd_nxt = API_Ver;
            REG_HDLVER: rd_nxt = HDL_VER;
            REG_CMD:    rd_nxt = cmd.Cmd_Word;
            REG_STATUS: rd_nxt = HDL_Status;
            REG_DLEN:   rd_nxt = Data_Length;
            REG_CLIP:   rd_nxt = Clip_No;
            default:    rd_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            Rd_Data <= '0;
        end else begin
            Rd_Data <= rd_nxt;
        end
    end

endmodule
